mod_bus_bridge: RTL and testbench

- Data-side bus bridge between the CPU data port and up to four memory-mapped slaves, such as the PLP ID block, UART and GPIO.
- Decodes the CPU address into a one-hot slave enable and strips the region base, so every slave sees offsets from 0.
- Inserts a configurable number of wait states.
- Registers read data and stalls the CPU until the response is ready.

---
 rtl/mod_bus_bridge_if.sv | 32 +++
 rtl/mod_bus_bridge.sv | 169 ++++++++++++++++
 tb/tb_mod_bus_bridge.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_bus_bridge_if.sv
// Bus bundle connecting the CPU data port, the bridge and up to four slaves.
interface mod_bus_bridge_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NS = 4;

  logic            cpu_de;
  logic [AW-1:0]   cpu_daddr;
  logic [1:0]      cpu_drw;
  logic [DW-1:0]   cpu_din;
  logic [DW-1:0]   cpu_dout;
  logic            cpu_stall;
  logic [NS-1:0]   s_de;
  logic [AW-1:0]   s_daddr;
  logic [1:0]      s_drw;
  logic [DW-1:0]   s_din;
  logic [NS*DW-1:0] s_dout;
  logic            err;
  logic [AW-1:0]   err_addr;

  // Bridge view: master towards the slaves, answering the CPU.
  modport master (
    input  cpu_de, cpu_daddr, cpu_drw, cpu_din, s_dout,
    output cpu_dout, cpu_stall, s_de, s_daddr, s_drw, s_din, err, err_addr
  );

  // Environment view: CPU plus slaves.
  modport slave (
    output cpu_de, cpu_daddr, cpu_drw, cpu_din, s_dout,
    input  cpu_dout, cpu_stall, s_de, s_daddr, s_drw, s_din, err, err_addr
  );
endinterface

// File: rtl/mod_bus_bridge.sv
// CPU data-side bridge to four memory-mapped slaves with wait states and registered read data.
// Optional macro BUS_ERR_EN: flags unmapped accesses on err/err_addr and returns 32'hdeadbeef on unmapped reads.
module mod_bus_bridge #(
  parameter logic [31:0] BASE0       = 32'h0000_0000,
  parameter logic [31:0] BASE1       = 32'hf000_0000,
  parameter logic [31:0] BASE2       = 32'hf010_0000,
  parameter logic [31:0] BASE3       = 32'hf020_0000,
  parameter logic [31:0] REGION_MASK = 32'hfff0_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic             clk,
  input logic             rst,
  mod_bus_bridge_if.master bus
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NS = 4;
  localparam int unsigned CW = 4;

  localparam logic [1:0] DRW_WR = 2'b01;
  localparam logic [1:0] DRW_RD = 2'b10;

  localparam logic [AW-1:0] BASES [NS] = '{BASE0, BASE1, BASE2, BASE3};

`ifdef BUS_ERR_EN
  localparam logic [DW-1:0] UNMAPPED_RD = 32'hdead_beef;
`else
  localparam logic [DW-1:0] UNMAPPED_RD = '0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] din_q,   din_d;
  logic [1:0]    drw_q,   drw_d;
  logic [NS-1:0] sel_q,   sel_d;
  logic [DW-1:0] rdata_q, rdata_d;
`ifdef BUS_ERR_EN
  logic          err_q,      err_d;
  logic [AW-1:0] err_addr_q, err_addr_d;
`endif

  logic          req_c;
  logic [NS-1:0] dec_sel_c;
  logic [DW-1:0] slice_c;

  assign req_c = bus.cpu_de && (bus.cpu_drw == DRW_WR || bus.cpu_drw == DRW_RD);

  // Region decode; the lowest matching slave index wins.
  always_comb begin
    logic found;
    found     = 1'b0;
    dec_sel_c = '0;
    for (int i = 0; i < NS; i++) begin
      if (!found && ((bus.cpu_daddr & REGION_MASK) == BASES[i])) begin
        dec_sel_c[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  always_comb begin
    slice_c = '0;
    for (int i = 0; i < NS; i++) begin
      if (sel_q[i]) slice_c = slice_c | bus.s_dout[i*DW +: DW];
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    din_d         = din_q;
    drw_d         = drw_q;
    sel_d         = sel_q;
    rdata_d       = rdata_q;
`ifdef BUS_ERR_EN
    err_d         = err_q;
    err_addr_d    = err_addr_q;
`endif
    bus.cpu_stall = 1'b0;
    bus.s_de      = '0;
    bus.s_drw     = '0;

    unique case (state_q)
      IDLE: begin
        if (req_c) begin
          bus.cpu_stall = 1'b1;
          addr_d        = bus.cpu_daddr;
          din_d         = bus.cpu_din;
          drw_d         = bus.cpu_drw;
          sel_d         = dec_sel_c;
          cnt_d         = CW'(WAIT_CYCLES);
          state_d       = ACCESS;
        end
      end
      ACCESS: begin
        bus.cpu_stall = 1'b1;
        bus.s_de      = sel_q;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Strobe only in the final access cycle so each transfer writes once.
          bus.s_drw = drw_q;
          if (drw_q == DRW_RD) rdata_d = (sel_q != '0) ? slice_c : UNMAPPED_RD;
          else                 rdata_d = '0;
`ifdef BUS_ERR_EN
          if (sel_q == '0) begin
            err_d      = 1'b1;
            err_addr_d = addr_q;
          end else if (drw_q == DRW_RD && sel_q[0] && (addr_q & ~REGION_MASK) == '0) begin
            err_d = 1'b0;
          end
`endif
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.s_daddr  = addr_q & ~REGION_MASK;
  assign bus.s_din    = din_q;
  assign bus.cpu_dout = rdata_q;

`ifdef BUS_ERR_EN
  assign bus.err      = err_q;
  assign bus.err_addr = err_addr_q;
`else
  assign bus.err      = 1'b0;
  assign bus.err_addr = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      drw_q   <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      drw_q   <= drw_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef BUS_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end
`endif

endmodule

// File: tb/tb_mod_bus_bridge.sv
// Self-checking bench for mod_bus_bridge: directed scenarios plus randomized traffic against a reference model.
module tb_mod_bus_bridge;
  localparam logic [31:0] MASK  = 32'hfff0_0000;
  localparam logic [31:0] BASES [4] = '{32'h0000_0000, 32'hf000_0000, 32'hf010_0000, 32'hf020_0000};
  localparam logic [1:0]  WR = 2'b01;
  localparam logic [1:0]  RD = 2'b10;
`ifdef BUS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_de;
  logic [31:0]  cpu_daddr, cpu_din;
  logic [1:0]   cpu_drw;
  logic [127:0] s_dout;

  always #5 clk = ~clk;

  mod_bus_bridge_if bus ();
  mod_bus_bridge_if bus_w0 ();
  mod_bus_bridge_if bus_w3 ();

  assign bus.cpu_de       = cpu_de;
  assign bus.cpu_daddr    = cpu_daddr;
  assign bus.cpu_drw      = cpu_drw;
  assign bus.cpu_din      = cpu_din;
  assign bus.s_dout       = s_dout;
  assign bus_w0.cpu_de    = cpu_de;
  assign bus_w0.cpu_daddr = cpu_daddr;
  assign bus_w0.cpu_drw   = cpu_drw;
  assign bus_w0.cpu_din   = cpu_din;
  assign bus_w0.s_dout    = s_dout;
  assign bus_w3.cpu_de    = cpu_de;
  assign bus_w3.cpu_daddr = cpu_daddr;
  assign bus_w3.cpu_drw   = cpu_drw;
  assign bus_w3.cpu_din   = cpu_din;
  assign bus_w3.s_dout    = s_dout;

  mod_bus_bridge #(.WAIT_CYCLES(1)) u_dut    (.clk(clk), .rst(rst), .bus(bus));
  mod_bus_bridge #(.WAIT_CYCLES(0)) u_dut_w0 (.clk(clk), .rst(rst), .bus(bus_w0));
  mod_bus_bridge #(.WAIT_CYCLES(3)) u_dut_w3 (.clk(clk), .rst(rst), .bus(bus_w3));

  int checks   = 0;
  int failures = 0;

  // Observations of the last transfer on the WAIT_CYCLES=1 bridge.
  int          o_stall, o_strobes, o_de_cycles;
  logic [3:0]  o_de;
  logic [1:0]  o_drw;
  logic [31:0] o_off, o_din, o_dout, o_err_addr;
  logic        o_err, o_resp_quiet;

  logic        exp_err;
  logic [31:0] exp_err_addr;

  function automatic logic [3:0] ref_sel(input logic [31:0] a);
    for (int i = 0; i < 4; i++) if ((a & MASK) == BASES[i]) return 4'(1 << i);
    return 4'b0000;
  endfunction

  function automatic logic [31:0] ref_rdata(input logic [31:0] a, input logic [1:0] drw,
                                            input logic [127:0] sd);
    logic [3:0] s;
    s = ref_sel(a);
    if (drw != RD) return 32'h0;
    for (int i = 0; i < 4; i++) if (s[i]) return sd[i*32 +: 32];
    return ERR_EN ? 32'hdead_beef : 32'h0;
  endfunction

  task automatic model_commit(input logic [31:0] a, input logic [1:0] drw);
    if (!ERR_EN) return;
    if (ref_sel(a) == 4'b0000) begin
      exp_err      = 1'b1;
      exp_err_addr = a;
    end else if (drw == RD && ref_sel(a) == 4'b0001 && (a & ~MASK) == 32'h0) begin
      exp_err = 1'b0;
    end
  endtask

  // One CPU transfer; optionally scrambles cpu_* while the bridge is busy.
  task automatic do_xfer(input logic [31:0] a, input logic [1:0] drw, input logic [31:0] wd,
                         input bit junk);
    bit done;
    done = 1'b0;
    o_stall = 0; o_strobes = 0; o_de_cycles = 0; o_de = '0; o_drw = '0;
    o_off = '0; o_din = '0; o_resp_quiet = 1'b0;
    @(negedge clk);
    cpu_de = 1'b1; cpu_daddr = a; cpu_drw = drw; cpu_din = wd;
    #1;
    if (bus.cpu_stall) o_stall++;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (bus.cpu_stall) begin
        o_stall++;
        if (bus.s_de != '0) o_de_cycles++;
        o_de = o_de | bus.s_de;
        if (bus.s_drw != '0) begin
          o_strobes++;
          o_drw = bus.s_drw;
          o_off = bus.s_daddr;
          o_din = bus.s_din;
        end
        if (junk) begin
          cpu_daddr = $urandom; cpu_din = $urandom;
          cpu_drw = 2'($urandom); cpu_de = 1'($urandom);
        end
      end else begin
        o_dout       = bus.cpu_dout;
        o_err        = bus.err;
        o_err_addr   = bus.err_addr;
        o_resp_quiet = (bus.s_de == '0) && (bus.s_drw == '0);
        cpu_de = 1'b0; cpu_drw = 2'b00;
        done = 1'b1;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL xfer_timeout addr=%h stall_cycles=%0d required=release", a, o_stall);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; cpu_de = 1'b0; cpu_drw = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_err = 1'b0; exp_err_addr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_de = 1'b0; cpu_drw = 2'b00; cpu_daddr = '0; cpu_din = '0; s_dout = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.cpu_stall, bus.s_de, bus.s_drw} !== 7'd0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0", {bus.cpu_stall, bus.s_de, bus.s_drw});
    end
    checks++;
    if (bus.cpu_dout !== 32'h0) begin
      failures++; $display("FAIL reset_dout got=%h exp=0", bus.cpu_dout);
    end
    checks++;
    if ({bus.s_daddr, bus.s_din} !== 64'h0) begin
      failures++; $display("FAIL reset_addr_data got=%h/%h exp=0", bus.s_daddr, bus.s_din);
    end
    checks++;
    if ({bus.err, bus.err_addr} !== 33'h0) begin
      failures++; $display("FAIL reset_err got=%b/%h exp=0", bus.err, bus.err_addr);
    end
    rst = 1'b0;
    exp_err = 1'b0; exp_err_addr = '0;
  endtask

  task automatic test_read_map();
    logic [31:0] a;
    s_dout = {$urandom, $urandom, $urandom, 32'h017d_7840};
    do_xfer(32'h0000_0004, RD, $urandom, 1'b0);
    model_commit(32'h0000_0004, RD);
    checks++;
    if (o_stall !== 3) begin failures++; $display("FAIL read_stall got=%0d exp=3", o_stall); end
    checks++;
    if (o_de !== 4'b0001 || o_de_cycles !== 2) begin
      failures++; $display("FAIL read_de got=%b x%0d exp=0001 x2", o_de, o_de_cycles);
    end
    checks++;
    if (o_off !== 32'h4) begin failures++; $display("FAIL read_offset got=%h exp=4", o_off); end
    checks++;
    if (o_strobes !== 1 || o_drw !== RD) begin
      failures++; $display("FAIL read_strobe got=%0d/%b exp=1/10", o_strobes, o_drw);
    end
    checks++;
    if (o_dout !== 32'h017d_7840) begin failures++; $display("FAIL read_data got=%h exp=017d7840", o_dout); end
    checks++;
    if (!o_resp_quiet) begin failures++; $display("FAIL resp_quiet got=0 exp=1"); end
    for (int n = 1; n < 4; n++) begin
      a = BASES[n] | ($urandom & 32'h000f_fffc);
      s_dout = {$urandom, $urandom, $urandom, $urandom};
      do_xfer(a, RD, $urandom, 1'b1);
      model_commit(a, RD);
      checks++;
      if (o_dout !== s_dout[n*32 +: 32] || o_de !== 4'(1 << n)) begin
        failures++;
        $display("FAIL read_slave%0d got=%h/%b exp=%h/%b", n, o_dout, o_de, s_dout[n*32 +: 32], 4'(1 << n));
      end
    end
  endtask

  task automatic test_write();
    do_xfer(32'hf010_0008, WR, 32'h0000_00aa, 1'b1);
    model_commit(32'hf010_0008, WR);
    checks++;
    if (o_de !== 4'b0100) begin failures++; $display("FAIL write_de got=%b exp=0100", o_de); end
    checks++;
    if (o_off !== 32'h8 || o_din !== 32'haa) begin
      failures++; $display("FAIL write_addr_data got=%h/%h exp=8/aa", o_off, o_din);
    end
    checks++;
    if (o_strobes !== 1 || o_drw !== WR) begin
      failures++; $display("FAIL write_strobe got=%0d/%b exp=1/01", o_strobes, o_drw);
    end
    checks++;
    if (o_stall !== 3 || o_dout !== 32'h0) begin
      failures++; $display("FAIL write_resp got=%0d/%h exp=3/0", o_stall, o_dout);
    end
  endtask

  task automatic test_back_to_back();
    int wr_strobes;
    wr_strobes = 0;
    s_dout = {$urandom, $urandom, $urandom, $urandom};
    do_xfer(32'hf000_0010, RD, $urandom, 1'b0);
    model_commit(32'hf000_0010, RD);
    if (o_drw == WR) wr_strobes += o_strobes;
    checks++;
    if (o_stall !== 3 || o_dout !== s_dout[63:32] || o_de !== 4'b0010) begin
      failures++; $display("FAIL b2b_read got=%0d/%h/%b exp=3/%h/0010", o_stall, o_dout, o_de, s_dout[63:32]);
    end
    do_xfer(32'hf020_0020, WR, 32'h1234_5678, 1'b0);
    model_commit(32'hf020_0020, WR);
    if (o_drw == WR) wr_strobes += o_strobes;
    checks++;
    if (o_stall !== 3 || o_de !== 4'b1000 || o_off !== 32'h20 || o_din !== 32'h1234_5678) begin
      failures++; $display("FAIL b2b_write got=%0d/%b/%h/%h exp=3/1000/20/12345678", o_stall, o_de, o_off, o_din);
    end
    checks++;
    if (wr_strobes !== 1) begin failures++; $display("FAIL b2b_wr_strobes got=%0d exp=1", wr_strobes); end
  endtask

  task automatic test_unmapped();
    do_xfer(32'h8000_0000, RD, $urandom, 1'b0);
    model_commit(32'h8000_0000, RD);
    checks++;
    if (o_de !== 4'b0000 || o_de_cycles !== 0) begin failures++; $display("FAIL unmapped_de got=%b exp=0000", o_de); end
    checks++;
    if (o_dout !== (ERR_EN ? 32'hdead_beef : 32'h0)) begin
      failures++; $display("FAIL unmapped_data got=%h exp=%h", o_dout, ERR_EN ? 32'hdead_beef : 32'h0);
    end
    checks++;
    if (o_err !== ERR_EN || o_err_addr !== (ERR_EN ? 32'h8000_0000 : 32'h0)) begin
      failures++; $display("FAIL unmapped_err got=%b/%h exp=%b", o_err, o_err_addr, ERR_EN);
    end
    do_xfer(32'hf010_0010, WR, $urandom, 1'b0);
    model_commit(32'hf010_0010, WR);
    checks++;
    if (o_err !== exp_err) begin failures++; $display("FAIL err_sticky got=%b exp=%b", o_err, exp_err); end
    s_dout = {$urandom, $urandom, $urandom, $urandom};
    do_xfer(32'h0000_0000, RD, $urandom, 1'b0);
    model_commit(32'h0000_0000, RD);
    checks++;
    if (o_err !== 1'b0 || o_dout !== s_dout[31:0]) begin
      failures++; $display("FAIL err_clear got=%b/%h exp=0/%h", o_err, o_dout, s_dout[31:0]);
    end
  endtask

  task automatic test_mid_reset();
    int bad_strobes;
    bad_strobes = 0;
    @(negedge clk);
    cpu_de = 1'b1; cpu_daddr = 32'hf010_0004; cpu_drw = WR; cpu_din = 32'h5a5a_5a5a;
    @(negedge clk);
    if (bus.s_drw == WR) bad_strobes++;
    cpu_de = 1'b0; cpu_drw = 2'b00; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_err = 1'b0; exp_err_addr = '0;
    checks++;
    if ({bus.cpu_stall, bus.s_de, bus.s_drw, bus.cpu_dout, bus.s_daddr, bus.s_din, bus.err} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got=%b/%b/%b/%h exp=0", bus.cpu_stall, bus.s_de, bus.s_drw, bus.cpu_dout);
    end
    repeat (5) begin
      @(negedge clk);
      if (bus.s_drw == WR) bad_strobes++;
    end
    checks++;
    if (bad_strobes !== 0) begin failures++; $display("FAIL midreset_strobe got=%0d exp=0", bad_strobes); end
  endtask

  task automatic test_random();
    int          r, gap;
    logic [31:0] a, wd, exp_dout;
    logic [1:0]  drw;
    logic [3:0]  exp_sel;
    for (int t = 0; t < 30; t++) begin
      r  = $urandom_range(0, 4);
      a  = (r == 4) ? (32'h8000_0000 | ($urandom & 32'h000f_fffc)) : (BASES[r] | ($urandom & 32'h000f_fffc));
      drw = ($urandom_range(0, 1) == 1) ? WR : RD;
      wd = $urandom;
      s_dout   = {$urandom, $urandom, $urandom, $urandom};
      exp_sel  = ref_sel(a);
      exp_dout = ref_rdata(a, drw, s_dout);
      do_xfer(a, drw, wd, 1'b1);
      model_commit(a, drw);
      checks++;
      if (o_stall !== 3 || o_de !== exp_sel || o_de_cycles !== ((exp_sel != 0) ? 2 : 0)) begin
        failures++; $display("FAIL rnd_ctrl t=%0d got=%0d/%b/%0d exp=3/%b", t, o_stall, o_de, o_de_cycles, exp_sel);
      end
      checks++;
      if (o_strobes !== 1 || o_drw !== drw || o_off !== (a & ~MASK) || o_din !== wd) begin
        failures++; $display("FAIL rnd_bus t=%0d got=%0d/%b/%h/%h exp=1/%b/%h/%h", t, o_strobes, o_drw, o_off, o_din, drw, a & ~MASK, wd);
      end
      checks++;
      if (o_dout !== exp_dout) begin failures++; $display("FAIL rnd_data t=%0d got=%h exp=%h", t, o_dout, exp_dout); end
      checks++;
      if (o_err !== exp_err || o_err_addr !== exp_err_addr) begin
        failures++; $display("FAIL rnd_err t=%0d got=%b/%h exp=%b/%h", t, o_err, o_err_addr, exp_err, exp_err_addr);
      end
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        checks++;
        if (bus.cpu_stall !== 1'b0 || bus.cpu_dout !== exp_dout) begin
          failures++; $display("FAIL rnd_hold t=%0d got=%b/%h exp=0/%h", t, bus.cpu_stall, bus.cpu_dout, exp_dout);
        end
      end
    end
  endtask

  task automatic test_wait_states();
    int          n0, n1, n3, e0, e3, r;
    bit          f0, f1, f3;
    logic [31:0] d0, d1, d3, a, exp_dout;
    apply_reset();
    for (int t = 0; t < 3; t++) begin
      r = $urandom_range(0, 3);
      a = BASES[r] | ($urandom & 32'h000f_fffc);
      s_dout = {$urandom, $urandom, $urandom, $urandom};
      exp_dout = ref_rdata(a, RD, s_dout);
      n0 = 0; n1 = 0; n3 = 0; e0 = 0; e3 = 0; f0 = 0; f1 = 0; f3 = 0;
      d0 = '0; d1 = '0; d3 = '0;
      @(negedge clk);
      cpu_de = 1'b1; cpu_daddr = a; cpu_drw = RD; cpu_din = $urandom;
      #1;
      if (bus_w0.cpu_stall) n0++;
      if (bus.cpu_stall)    n1++;
      if (bus_w3.cpu_stall) n3++;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        cpu_de = 1'b0; cpu_drw = 2'b00;
        if (!f0) begin
          if (bus_w0.cpu_stall) begin n0++; if (bus_w0.s_de != '0) e0++; end
          else begin f0 = 1'b1; d0 = bus_w0.cpu_dout; end
        end
        if (!f1) begin
          if (bus.cpu_stall) n1++;
          else begin f1 = 1'b1; d1 = bus.cpu_dout; end
        end
        if (!f3) begin
          if (bus_w3.cpu_stall) begin n3++; if (bus_w3.s_de != '0) e3++; end
          else begin f3 = 1'b1; d3 = bus_w3.cpu_dout; end
        end
      end
      model_commit(a, RD);
      checks++;
      if (n0 !== 2 || e0 !== 1 || d0 !== exp_dout) begin
        failures++; $display("FAIL wait0 t=%0d got=%0d/%0d/%h exp=2/1/%h", t, n0, e0, d0, exp_dout);
      end
      checks++;
      if (n1 !== 3 || d1 !== exp_dout) begin
        failures++; $display("FAIL wait1 t=%0d got=%0d/%h exp=3/%h", t, n1, d1, exp_dout);
      end
      checks++;
      if (n3 !== 5 || e3 !== 4 || d3 !== exp_dout) begin
        failures++; $display("FAIL wait3 t=%0d got=%0d/%0d/%h exp=5/4/%h", t, n3, e3, d3, exp_dout);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_map();
    test_write();
    test_back_to_back();
    test_unmapped();
    test_mid_reset();
    test_random();
    test_wait_states();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
